// File: rtl/mandel_coor_gen_pkg.sv
// Shared constants for the Mandelbrot coordinate generator: default geometry,
// Q8.24 format, reset defaults of the view configuration and FSM encoding.
package mandel_coor_gen_pkg;

   localparam int NUM_PROC_DEF = 8;
   localparam int FRAC_W       = 24;
   localparam int H_RES_DEF    = 640;
   localparam int V_RES_DEF    = 480;

   // Default view: real axis from -2.0, imaginary axis from +1.125
   localparam logic [31:0] X0_RST   = 32'hFE00_0000;
   localparam logic [31:0] Y0_RST   = 32'h0120_0000;
   localparam logic [31:0] STEP_RST = 32'h0001_3333;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2
   } state_e;

endpackage

// File: rtl/mandel_coor_gen_lsb_prio_enc.sv
// Lowest-index-wins priority encoder: binary index of the lowest set request
// bit plus a valid flag.
module lsb_prio_enc #(
   parameter int N = 8,
   parameter int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] req_i,
   output logic [W-1:0] idx_o,
   output logic         valid_o
);

   always_comb begin
      idx_o   = '0;
      valid_o = |req_i;
      // Walk downwards so the lowest set bit is the last one written
      for (int i = N - 1; i >= 0; i--) begin
         if (req_i[i]) idx_o = W'(i);
      end
   end

endmodule

// File: rtl/mandel_coor_gen.sv
// Scans the pixel grid column-major, keeps each pixel's complex coordinate by
// incremental add/subtract and dispatches one pixel per cycle to an idle engine.
//
// state | meaning
// IDLE  | waiting for crun
// LOAD  | one cycle: active cfg <= shadow cfg, scan position reset to (0,0)
// RUN   | dispatching pixels until (H_RES-1, V_RES-1) has been sent
module mandel_coor_gen
   import mandel_coor_gen_pkg::*;
#(
   parameter int NUM_PROC = NUM_PROC_DEF,
   parameter int ADDR_W   = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1,
   parameter int H_RES    = H_RES_DEF,
   parameter int V_RES    = V_RES_DEF,
   parameter int XW       = $clog2(H_RES),
   parameter int YW       = $clog2(V_RES),
   parameter int COOR_W   = 32
) (
   input  logic                         cclk,
   input  logic                         creset,
   input  logic [NUM_PROC-1:0]          cdones,
   input  logic                         crun,
   input  logic                         ccfg_load,
   input  logic [COOR_W-1:0]            ccfg_x0,
   input  logic [COOR_W-1:0]            ccfg_y0,
   input  logic [COOR_W-1:0]            ccfg_step,
   output logic                         clatch_en,
   output logic [ADDR_W-1:0]            cengine_addr,
   output logic [XW+YW+2*COOR_W-1:0]    cword2engines,
   output logic                         cframe_start,
   output logic                         cframe_done,
   output logic                         cbusy
);

   localparam int WORD_W = XW + YW + 2 * COOR_W;
   localparam logic [XW-1:0] PX_LAST = XW'(H_RES - 1);
   localparam logic [YW-1:0] PY_LAST = YW'(V_RES - 1);

   state_e              state_q, state_d;
   logic [COOR_W-1:0]   sh_x0_q, sh_y0_q, sh_step_q;
   logic [COOR_W-1:0]   act_y0_q, act_y0_d, act_step_q, act_step_d;
   logic [XW-1:0]       px_q, px_d;
   logic [YW-1:0]       py_q, py_d;
   logic [COOR_W-1:0]   cx_q, cx_d, cy_q, cy_d;
   logic [NUM_PROC-1:0] pend_q, pend_d;
   logic                latch_q, done_q, start_q, busy_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [WORD_W-1:0]   word_q;

   logic [NUM_PROC-1:0] elig;
   logic [ADDR_W-1:0]   sel_idx;
   logic                sel_vld, dispatch, last_pix;
   logic [COOR_W-1:0]   x0_eff, y0_eff, step_eff;

   assign elig     = cdones & ~pend_q;
   assign dispatch = (state_q == ST_RUN) && sel_vld;
   assign last_pix = (px_q == PX_LAST) && (py_q == PY_LAST);

   // A config write landing in the LOAD cycle itself is used for the new frame
   assign x0_eff   = ccfg_load ? ccfg_x0   : sh_x0_q;
   assign y0_eff   = ccfg_load ? ccfg_y0   : sh_y0_q;
   assign step_eff = ccfg_load ? ccfg_step : sh_step_q;

   lsb_prio_enc #(.N(NUM_PROC), .W(ADDR_W)) u_prio (
      .req_i   (elig),
      .idx_o   (sel_idx),
      .valid_o (sel_vld)
   );

   always_comb begin
      state_d    = state_q;
      act_y0_d   = act_y0_q;
      act_step_d = act_step_q;
      px_d       = px_q;
      py_d       = py_q;
      cx_d       = cx_q;
      cy_d       = cy_q;
      pend_d     = pend_q & cdones;
      case (state_q)
         ST_IDLE: begin
            if (crun) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            act_y0_d   = y0_eff;
            act_step_d = step_eff;
            px_d       = '0;
            py_d       = '0;
            cx_d       = x0_eff;
            cy_d       = y0_eff;
            state_d    = ST_RUN;
         end
         ST_RUN: begin
            if (dispatch) begin
               pend_d[sel_idx] = 1'b1;
               if (py_q == PY_LAST) begin
                  py_d = '0;
                  cy_d = act_y0_q;
                  px_d = px_q + XW'(1);
                  cx_d = cx_q + act_step_q;
               end else begin
                  py_d = py_q + YW'(1);
                  cy_d = cy_q - act_step_q;
               end
               if (last_pix) state_d = crun ? ST_LOAD : ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge cclk or negedge creset) begin
      if (!creset) begin
         state_q    <= ST_IDLE;
         sh_x0_q    <= COOR_W'(X0_RST);
         sh_y0_q    <= COOR_W'(Y0_RST);
         sh_step_q  <= COOR_W'(STEP_RST);
         act_y0_q   <= COOR_W'(Y0_RST);
         act_step_q <= COOR_W'(STEP_RST);
         px_q       <= '0;
         py_q       <= '0;
         cx_q       <= '0;
         cy_q       <= '0;
         pend_q     <= '0;
         latch_q    <= 1'b0;
         addr_q     <= '0;
         word_q     <= '0;
         done_q     <= 1'b0;
         start_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         act_y0_q   <= act_y0_d;
         act_step_q <= act_step_d;
         px_q       <= px_d;
         py_q       <= py_d;
         cx_q       <= cx_d;
         cy_q       <= cy_d;
         pend_q     <= pend_d;
         if (ccfg_load) begin
            sh_x0_q   <= ccfg_x0;
            sh_y0_q   <= ccfg_y0;
            sh_step_q <= ccfg_step;
         end
         latch_q <= dispatch;
         if (dispatch) begin
            addr_q <= sel_idx;
            word_q <= {px_q, py_q, cx_q, cy_q};
         end
         done_q  <= dispatch && last_pix;
         start_q <= (state_d == ST_LOAD);
         busy_q  <= (state_d != ST_IDLE);
      end
   end

   assign clatch_en     = latch_q;
   assign cengine_addr  = addr_q;
   assign cword2engines = word_q;
   assign cframe_done   = done_q;
   assign cframe_start  = start_q;
   assign cbusy         = busy_q;

endmodule

// File: tb/tb_mandel_coor_gen.sv
// Self-checking bench for mandel_coor_gen on a 4x3 grid with four engines;
// randomized engine busy times against a per-pixel arithmetic reference.
module tb_mandel_coor_gen;

   localparam int NP = 4;
   localparam int HR = 4;
   localparam int VR = 3;
   localparam int XW = 2;
   localparam int YW = 2;
   localparam int CW = 32;
   localparam int AW = 2;
   localparam int WW = XW + YW + 2 * CW;
   localparam int NPIX = HR * VR;
   localparam logic [31:0] DX0 = 32'hFE00_0000;
   localparam logic [31:0] DY0 = 32'h0120_0000;
   localparam logic [31:0] DST = 32'h0001_3333;

   logic          cclk = 1'b0;
   logic          creset = 1'b0;
   logic [NP-1:0] cdones = '1;
   logic          crun = 1'b0;
   logic          ccfg_load = 1'b0;
   logic [CW-1:0] ccfg_x0 = '0, ccfg_y0 = '0, ccfg_step = '0;
   logic          clatch_en, cframe_start, cframe_done, cbusy;
   logic [AW-1:0] cengine_addr;
   logic [WW-1:0] cword2engines;

   mandel_coor_gen #(
      .NUM_PROC(NP), .ADDR_W(AW), .H_RES(HR), .V_RES(VR),
      .XW(XW), .YW(YW), .COOR_W(CW)
   ) dut (
      .cclk(cclk), .creset(creset), .cdones(cdones), .crun(crun),
      .ccfg_load(ccfg_load), .ccfg_x0(ccfg_x0), .ccfg_y0(ccfg_y0),
      .ccfg_step(ccfg_step), .clatch_en(clatch_en), .cengine_addr(cengine_addr),
      .cword2engines(cword2engines), .cframe_start(cframe_start),
      .cframe_done(cframe_done), .cbusy(cbusy)
   );

   always #5 cclk = ~cclk;

   int n_checks = 0;
   int n_pass   = 0;

   // engine model: 0 idle with done high, 1 latched but done still high, 2 busy
   int            ph[NP];
   int            cnt[NP];
   logic [NP-1:0] en_auto, man_dones, elig_m;
   bit            sb_on, run_cur, load_cur, prev_strobe, b2b_seen;
   int            pix_k, n_done, n_start;
   logic [31:0]   sh_x0, sh_y0, sh_st, ac_x0, ac_y0, ac_st;
   logic [WW-1:0] log_w[$];

   function automatic logic [WW-1:0] exp_word(int k, logic [31:0] x0, logic [31:0] y0,
                                              logic [31:0] st);
      logic [XW-1:0] px;
      logic [YW-1:0] py;
      logic [31:0]   cx, cy;
      px = XW'(k / VR);
      py = YW'(k % VR);
      cx = x0 + 32'(k / VR) * st;
      cy = y0 - 32'(k % VR) * st;
      return {px, py, cx, cy};
   endfunction

   function automatic int lowest(logic [NP-1:0] v);
      for (int i = 0; i < NP; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic drive_dones();
      for (int j = 0; j < NP; j++) begin
         elig_m[j] = en_auto[j] && (ph[j] == 0);
         cdones[j] = en_auto[j] ? (ph[j] != 2) : man_dones[j];
      end
   endtask

   task automatic init_model();
      for (int j = 0; j < NP; j++) begin ph[j] = 0; cnt[j] = 0; end
      run_cur = 0; load_cur = 0; pix_k = 0; n_done = 0; n_start = 0;
      prev_strobe = 0; b2b_seen = 0;
      sh_x0 = DX0; sh_y0 = DY0; sh_st = DST;
      ac_x0 = DX0; ac_y0 = DY0; ac_st = DST;
      log_w.delete();
      drive_dones();
   endtask

   task automatic do_reset();
      @(posedge cclk); #1;
      creset = 1'b0; crun = 1'b0; ccfg_load = 1'b0;
      init_model();
      repeat (3) @(posedge cclk);
      #1 creset = 1'b1;
   endtask

   // One clock: sample at edge+1, score against the reference, step the engines.
   task automatic cycle();
      logic [NP-1:0] elig_was;
      bit was_run, was_load, was_idle, crun_was, cfg_was, strobe, fin, exp_start;
      logic [WW-1:0] ew;
      elig_was = elig_m; was_run = run_cur; was_load = load_cur;
      was_idle = !was_run && !was_load;
      crun_was = crun; cfg_was = ccfg_load;
      @(posedge cclk); #1;
      if (cfg_was) begin sh_x0 = ccfg_x0; sh_y0 = ccfg_y0; sh_st = ccfg_step; end
      if (was_load) begin
         ac_x0 = sh_x0; ac_y0 = sh_y0; ac_st = sh_st; pix_k = 0;
         log_w.delete();
      end
      strobe = (clatch_en === 1'b1);
      fin = strobe && was_run && (pix_k == NPIX - 1);
      exp_start = crun_was && (was_idle || fin);
      if (cframe_start === 1'b1) n_start++;
      if (strobe) begin
         log_w.push_back(cword2engines);
         if (cframe_done === 1'b1) n_done++;
         if (prev_strobe) b2b_seen = 1;
      end
      if (sb_on) begin
         n_checks++;
         if (strobe !== (was_run && elig_was != 0))
            $display("FAIL sb_strobe: got %0b exp %0b (pix %0d)", strobe,
                     was_run && elig_was != 0, pix_k);
         else n_pass++;
         n_checks++;
         if (cframe_start !== exp_start)
            $display("FAIL sb_start: got %0b exp %0b", cframe_start, exp_start);
         else n_pass++;
         if (strobe) begin
            ew = exp_word(pix_k, ac_x0, ac_y0, ac_st);
            n_checks++;
            if (cword2engines !== ew)
               $display("FAIL sb_word pix %0d: got %h exp %h", pix_k, cword2engines, ew);
            else n_pass++;
            n_checks++;
            if (cengine_addr !== AW'(lowest(elig_was)))
               $display("FAIL sb_addr: got %0d exp %0d", cengine_addr, lowest(elig_was));
            else n_pass++;
            n_checks++;
            if (cframe_done !== (pix_k == NPIX - 1))
               $display("FAIL sb_done pix %0d: got %0b", pix_k, cframe_done);
            else n_pass++;
         end
      end
      if (strobe) pix_k++;
      load_cur = exp_start;
      run_cur  = was_load || (was_run && !fin);
      if (sb_on) begin
         n_checks++;
         if (cbusy !== (run_cur || load_cur))
            $display("FAIL sb_busy: got %0b exp %0b", cbusy, run_cur || load_cur);
         else n_pass++;
      end
      for (int j = 0; j < NP; j++) begin
         if (ph[j] == 2) begin
            if (cnt[j] <= 1) ph[j] = 0; else cnt[j]--;
         end else if (ph[j] == 1) begin
            if (cnt[j] == 0) begin ph[j] = 2; cnt[j] = $urandom_range(1, 5); end
            else cnt[j]--;
         end
      end
      if (strobe && en_auto[cengine_addr]) begin
         ph[cengine_addr]  = 1;
         cnt[cengine_addr] = $urandom_range(0, 1);
      end
      prev_strobe = strobe;
      drive_dones();
   endtask

   task automatic run_until_idle(int max);
      int i = 0;
      do begin cycle(); i++; end while (cbusy === 1'b1 && i < max);
      n_checks++;
      if (cbusy !== 1'b0) $display("FAIL idle_timeout: cbusy %0b after %0d cycles", cbusy, i);
      else n_pass++;
   endtask

   task automatic wait_strobe(int max);
      int i = 0;
      do begin cycle(); i++; end while (clatch_en !== 1'b1 && i < max);
      n_checks++;
      if (clatch_en !== 1'b1) $display("FAIL strobe_timeout: none in %0d cycles", max);
      else n_pass++;
   endtask

   task automatic test_reset();
      en_auto = '1; man_dones = '0; sb_on = 1;
      init_model();
      creset = 1'b0;
      repeat (3) @(posedge cclk);
      #1;
      n_checks++;
      if ({clatch_en, cframe_start, cframe_done, cbusy} !== 4'b0)
         $display("FAIL rst_flags: got %b exp 0000", {clatch_en, cframe_start, cframe_done, cbusy});
      else n_pass++;
      n_checks++;
      if (cengine_addr !== '0) $display("FAIL rst_addr: got %0d exp 0", cengine_addr);
      else n_pass++;
      n_checks++;
      if (cword2engines !== '0) $display("FAIL rst_word: got %h exp 0", cword2engines);
      else n_pass++;
      creset = 1'b1; crun = 1'b1;
      cycle();
      n_checks++;
      if (cframe_start !== 1'b1 || clatch_en !== 1'b0)
         $display("FAIL rst_first_load: start %0b latch %0b exp 1 0", cframe_start, clatch_en);
      else n_pass++;
      cycle();
      cycle();
      n_checks++;
      if (clatch_en !== 1'b1 || cengine_addr !== 2'd0 ||
          cword2engines !== {2'd0, 2'd0, 32'hFE00_0000, 32'h0120_0000})
         $display("FAIL rst_first_pixel: latch %0b addr %0d word %h", clatch_en,
                  cengine_addr, cword2engines);
      else n_pass++;
      crun = 1'b0;
      run_until_idle(200);
      n_checks++;
      if (n_done !== 1) $display("FAIL rst_frame_done_count: got %0d exp 1", n_done);
      else n_pass++;
   endtask

   task automatic test_tiny_frame();
      do_reset();
      en_auto = 4'b0001; man_dones = '0; drive_dones();
      crun = 1'b1;
      cycle();
      crun = 1'b0;
      run_until_idle(300);
      n_checks++;
      if (log_w.size() != NPIX) $display("FAIL tiny_count: got %0d exp %0d", log_w.size(), NPIX);
      else n_pass++;
      n_checks++;
      if (log_w.size() == NPIX && log_w[5][63:0] !== {32'hFE01_3333, 32'h011D_999A})
         $display("FAIL tiny_pix_1_2: got %h exp fe013333011d999a", log_w[5][63:0]);
      else n_pass++;
      n_checks++;
      if (n_done !== 1 || n_start !== 1)
         $display("FAIL tiny_frame_pulses: done %0d start %0d exp 1 1", n_done, n_start);
      else n_pass++;
   endtask

   task automatic test_priority();
      int extra = 0;
      do_reset();
      en_auto = '0; man_dones = 4'b1010; sb_on = 0; drive_dones();
      crun = 1'b1;
      wait_strobe(10);
      n_checks++;
      if (cengine_addr !== 2'd1 || cword2engines !== exp_word(0, DX0, DY0, DST))
         $display("FAIL prio_first: addr %0d word %h exp 1 %h", cengine_addr,
                  cword2engines, exp_word(0, DX0, DY0, DST));
      else n_pass++;
      cycle();
      n_checks++;
      if (clatch_en !== 1'b1 || cengine_addr !== 2'd3 ||
          cword2engines !== exp_word(1, DX0, DY0, DST))
         $display("FAIL prio_second: latch %0b addr %0d word %h", clatch_en, cengine_addr,
                  cword2engines);
      else n_pass++;
      repeat (5) begin cycle(); if (clatch_en === 1'b1) extra++; end
      n_checks++;
      if (extra != 0) $display("FAIL prio_no_redispatch: got %0d strobes exp 0", extra);
      else n_pass++;
      man_dones = 4'b1000; drive_dones();
      cycle();
      man_dones = 4'b1010; drive_dones();
      wait_strobe(4);
      n_checks++;
      if (cengine_addr !== 2'd1 || cword2engines !== exp_word(2, DX0, DY0, DST))
         $display("FAIL prio_redispatch: addr %0d word %h exp 1 %h", cengine_addr,
                  cword2engines, exp_word(2, DX0, DY0, DST));
      else n_pass++;
      crun = 1'b0; sb_on = 1;
   endtask

   task automatic test_back_to_back();
      int i = 0;
      do_reset();
      en_auto = '1; drive_dones();
      crun = 1'b1;
      while (n_done < 2 && i < 400) begin cycle(); i++; end
      crun = 1'b0;
      run_until_idle(300);
      n_checks++;
      if (n_done !== 3 || n_start !== 3)
         $display("FAIL b2b_frames: done %0d start %0d exp 3 3", n_done, n_start);
      else n_pass++;
      n_checks++;
      if (!b2b_seen) $display("FAIL b2b_consecutive: got 0 exp 1");
      else n_pass++;
   endtask

   task automatic test_cfg_midframe();
      int i = 0;
      logic [31:0] ny0;
      do_reset();
      en_auto = '1; drive_dones();
      crun = 1'b1;
      while (pix_k < 4 && i < 100) begin cycle(); i++; end
      ny0 = $urandom;
      ccfg_x0 = 32'h0; ccfg_y0 = ny0; ccfg_step = 32'h0001_0000; ccfg_load = 1'b1;
      cycle();
      ccfg_load = 1'b0;
      i = 0;
      while (n_start < 2 && i < 200) begin cycle(); i++; end
      crun = 1'b0;
      run_until_idle(300);
      n_checks++;
      if (log_w.size() != NPIX || log_w[6][63:32] !== 32'h0002_0000 || log_w[6][31:0] !== ny0)
         $display("FAIL cfg_next_frame_pix_2_0: n %0d word %h exp cx 00020000 cy %h",
                  log_w.size(), log_w.size() > 6 ? log_w[6] : '0, ny0);
      else n_pass++;
      n_checks++;
      if (n_done !== 2) $display("FAIL cfg_frames: got %0d exp 2", n_done);
      else n_pass++;
   endtask

   task automatic test_crun_drop();
      int i = 0;
      do_reset();
      en_auto = '1; drive_dones();
      crun = 1'b1;
      while (pix_k < 5 && i < 100) begin cycle(); i++; end
      crun = 1'b0;
      run_until_idle(300);
      n_checks++;
      if (n_done !== 1 || n_start !== 1 || log_w.size() != NPIX || cbusy !== 1'b0)
         $display("FAIL crun_drop: done %0d start %0d pix %0d busy %0b exp 1 1 %0d 0",
                  n_done, n_start, log_w.size(), cbusy, NPIX);
      else n_pass++;
   endtask

   task automatic test_async_reset();
      int i = 0;
      do_reset();
      en_auto = '1; drive_dones();
      crun = 1'b1;
      do begin cycle(); i++; end
      while (!(clatch_en === 1'b1 && cword2engines[WW-1 -: 4] === 4'b1001) && i < 100);
      #2 creset = 1'b0;
      #1;
      n_checks++;
      if ({clatch_en, cframe_start, cframe_done, cbusy} !== 4'b0 || cengine_addr !== '0 ||
          cword2engines !== '0)
         $display("FAIL async_clear: flags %b addr %0d word %h exp all 0",
                  {clatch_en, cframe_start, cframe_done, cbusy}, cengine_addr, cword2engines);
      else n_pass++;
      init_model();
      @(posedge cclk); #1;
      creset = 1'b1;
      wait_strobe(10);
      n_checks++;
      if (cword2engines !== exp_word(0, DX0, DY0, DST))
         $display("FAIL async_restart: got %h exp %h", cword2engines, exp_word(0, DX0, DY0, DST));
      else n_pass++;
      crun = 1'b0;
      run_until_idle(300);
   endtask

   initial begin
      test_reset();
      test_tiny_frame();
      test_priority();
      test_back_to_back();
      test_cfg_midframe();
      test_crun_drop();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
